// File: rtl/num_char_builder.sv
// Scans an N x N board held in cell-status RAM and fills a 1024x8 character
// buffer with one glyph code per cell (hidden, mine, blank or neighbour count).
module num_char_builder #(
   parameter int unsigned GRID_MAX   = 32,
   parameter logic [7:0]  CHAR_BLANK = 8'h20,
   parameter logic [7:0]  CHAR_MINE  = 8'h2A,
   parameter logic [7:0]  CHAR_ZERO  = 8'h30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] board_dim,
   output logic [9:0] cell_addr,
   input  logic [1:0] cell_data,
   input  logic [9:0] char_xy,
   output logic [7:0] char_code,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, SCAN, WRITE, FINISH} state_t;
   typedef struct packed {
      logic       ok;
      logic [9:0] addr;
   } probe_t;

   localparam logic [5:0] GRID_N = 6'(GRID_MAX);

   state_t     state;
   logic [5:0] n;
   logic [5:0] n_clamp;
   logic [5:0] last;
   logic [4:0] col;
   logic [4:0] row;
   logic [4:0] next_col;
   logic [4:0] next_row;
   logic [3:0] k;
   logic [3:0] cnt;
   logic       rev;
   logic       mine;
   logic       probe_ok;
   logic       ok_d;
   logic       wr_en;
   logic [7:0] wr_code;
   logic [7:0] buffer [0:1023];

   // Out-of-range neighbours fall back to the centre address; ok masks their data.
   function automatic probe_t probe(input logic [4:0] c, input logic [4:0] r,
                                    input logic [3:0] idx, input logic [5:0] dim);
      logic signed [6:0] dc;
      logic signed [6:0] dr;
      logic signed [6:0] cc;
      logic signed [6:0] rr;
      logic signed [6:0] lim;
      probe_t            p;
      dc = '0;
      dr = '0;
      case (idx)
         4'd1:    begin dc = -7'sd1; dr = -7'sd1; end
         4'd2:    begin dc =  7'sd0; dr = -7'sd1; end
         4'd3:    begin dc =  7'sd1; dr = -7'sd1; end
         4'd4:    begin dc = -7'sd1; dr =  7'sd0; end
         4'd5:    begin dc =  7'sd1; dr =  7'sd0; end
         4'd6:    begin dc = -7'sd1; dr =  7'sd1; end
         4'd7:    begin dc =  7'sd0; dr =  7'sd1; end
         4'd8:    begin dc =  7'sd1; dr =  7'sd1; end
         default: begin dc =  7'sd0; dr =  7'sd0; end
      endcase
      cc  = $signed({2'b00, c}) + dc;
      rr  = $signed({2'b00, r}) + dr;
      lim = $signed({1'b0, dim});
      p.ok   = (cc >= 7'sd0) && (cc < lim) && (rr >= 7'sd0) && (rr < lim);
      p.addr = p.ok ? {cc[4:0], rr[4:0]} : {c, r};
      return p;
   endfunction

   always_comb begin
      n_clamp  = (board_dim > GRID_N) ? GRID_N : board_dim;
      last     = n - 6'd1;
      next_col = col + 5'd1;
      next_row = row;
      if ({1'b0, col} == last) begin
         next_col = '0;
         next_row = row + 5'd1;
      end
      wr_code = CHAR_BLANK;
      if (rev) begin
         if (mine)
            wr_code = CHAR_MINE;
         else if (cnt != '0)
            wr_code = CHAR_ZERO + {4'd0, cnt};
      end
      wr_en = (state == WRITE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         cell_addr <= '0;
         n         <= '0;
         col       <= '0;
         row       <= '0;
         k         <= '0;
         cnt       <= '0;
         rev       <= 1'b0;
         mine      <= 1'b0;
         probe_ok  <= 1'b0;
         ok_d      <= 1'b0;
      end else begin
         done <= 1'b0;
         ok_d <= probe_ok;
         case (state)
            IDLE: begin
               if (start) begin
                  n         <= n_clamp;
                  col       <= '0;
                  row       <= '0;
                  k         <= '0;
                  cnt       <= '0;
                  cell_addr <= '0;
                  probe_ok  <= 1'b1;
                  if (n_clamp == '0) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state <= SCAN;
                     busy  <= 1'b1;
                  end
               end
            end
            SCAN: begin
               // Data seen in cycle k belongs to the address issued in cycle k-1.
               if (k == 4'd1)
                  {rev, mine} <= cell_data;
               else if (k >= 4'd2 && ok_d && cell_data[0])
                  cnt <= cnt + 4'd1;
               if (k == 4'd9) begin
                  state <= WRITE;
               end else begin
                  k <= k + 4'd1;
                  if (k < 4'd8)
                     {probe_ok, cell_addr} <= probe(col, row, k + 4'd1, n);
               end
            end
            WRITE: begin
               if ({1'b0, col} == last && {1'b0, row} == last) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  col       <= next_col;
                  row       <= next_row;
                  k         <= '0;
                  cnt       <= '0;
                  cell_addr <= {next_col, next_row};
                  probe_ok  <= 1'b1;
                  state     <= SCAN;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst)
         buffer[{col, row}] <= wr_code;
   end

   always_ff @(posedge clk) begin
      if (rst)
         char_code <= '0;
      else
         char_code <= buffer[char_xy];
   end

endmodule

// File: tb/tb_num_char_builder.sv
// Scoreboard bench for num_char_builder: stimulus pushes expected read codes
// and done timing into queues; monitor pops them as the DUT presents results.
module tb_num_char_builder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [5:0] board_dim;
   logic [9:0] cell_addr;
   logic [1:0] cell_data;
   logic [9:0] char_xy;
   logic [7:0] char_code;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   num_char_builder #(.GRID_MAX(32), .CHAR_BLANK(8'h20), .CHAR_MINE(8'h2A), .CHAR_ZERO(8'h30)) dut (
      .clk(clk), .rst(rst), .start(start), .board_dim(board_dim),
      .cell_addr(cell_addr), .cell_data(cell_data), .char_xy(char_xy),
      .char_code(char_code), .busy(busy), .done(done)
   );

   // Cell-status RAM model: {revealed, mine}, one clock read latency.
   logic [1:0] status [0:1023];
   always @(posedge clk) cell_data <= status[cell_addr];

   typedef struct {
      int lat;
      int busy_cycles;
   } done_exp_t;

   logic [7:0] rd_q[$];
   string      rd_name_q[$];
   done_exp_t  done_q[$];

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   busy_cnt = 0;
   int   done_cnt = 0;
   int   done_snap = 0;
   logic rd_req = 1'b0;
   logic rd_v = 1'b0;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      rd_v <= rd_req;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compares every presented read and every done pulse.
   logic [7:0] m_exp;
   string      m_name;
   done_exp_t  m_de;
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (rd_v) begin
         if (rd_q.size() == 0) begin
            chk("read_unexpected", 1, 0);
         end else begin
            m_exp  = rd_q.pop_front();
            m_name = rd_name_q.pop_front();
            chk(m_name, {24'd0, char_code}, {24'd0, m_exp});
         end
      end
      if (done) begin
         done_cnt++;
         if (done_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
         end else begin
            m_de = done_q.pop_front();
            chk("done_latency", cyc - start_cyc + 1, m_de.lat);
            chk("busy_cycles", busy_cnt, m_de.busy_cycles);
            chk("busy_low_at_done", {31'd0, busy}, 0);
         end
      end
   end

   function automatic logic [9:0] xy(input int c, input int r);
      return {5'(c), 5'(r)};
   endfunction

   task automatic fill(input logic [1:0] v);
      for (int i = 0; i < 1024; i++) status[i] = v;
   endtask

   task automatic put(input int c, input int r, input logic [1:0] v);
      status[xy(c, r)] = v;
   endtask

   task automatic read_char(input string nm, input logic [9:0] a, input logic [7:0] exp);
      @(negedge clk);
      char_xy = a;
      rd_req  = 1'b1;
      rd_q.push_back(exp);
      rd_name_q.push_back(nm);
      @(posedge clk);
      #1 rd_req = 1'b0;
   endtask

   task automatic issue_start(input logic [5:0] dim, input int expn);
      done_exp_t e;
      e.lat         = 11 * expn * expn + 2;
      e.busy_cycles = 11 * expn * expn;
      @(negedge clk);
      board_dim = dim;
      start     = 1'b1;
      start_cyc = cyc;
      busy_cnt  = 0;
      done_snap = done_cnt;
      done_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int t;
      t = 0;
      while (done_cnt == done_snap && t < bound) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt == done_snap) begin
         chk("done_timeout", 0, 1);
         done_q.delete();
      end
      @(negedge clk);
      chk("done_single_pulse", {31'd0, done}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      rst = 1'b1; start = 1'b0; board_dim = '0; char_xy = '0;
      fill(2'b00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_cell_addr", {22'd0, cell_addr}, 0);
      chk("rst_char_code", {24'd0, char_code}, 0);
      rst = 1'b0;

      // 3x3, all revealed, centre mined.
      fill(2'b10); put(1, 1, 2'b11);
      issue_start(6'd3, 3);
      wait_done(200);
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 3; r++)
            read_char("t1_cell", xy(c, r), (c == 1 && r == 1) ? 8'h2A : 8'h31);

      // N=0 leaves the buffer untouched even though the board changed.
      fill(2'b00);
      issue_start(6'd0, 0);
      wait_done(10);
      read_char("t5_n0_untouched", xy(1, 1), 8'h2A);

      // 4x4, all mined except two corners: no wrap-around.
      fill(2'b11); put(0, 0, 2'b10); put(3, 3, 2'b10);
      issue_start(6'd4, 4);
      wait_done(300);
      read_char("t2_corner00", xy(0, 0), 8'h33);
      read_char("t2_corner33", xy(3, 3), 8'h33);
      read_char("t2_mine10", xy(1, 0), 8'h2A);
      read_char("t2_mine30", xy(3, 0), 8'h2A);

      // 2x2, nothing revealed.
      fill(2'b00); put(1, 0, 2'b01);
      issue_start(6'd2, 2);
      wait_done(100);
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 2; r++)
            read_char("t3_hidden", xy(c, r), 8'h20);

      // 8x8 with a start re-pulse mid-scan.
      fill(2'b10); put(2, 2, 2'b11); put(7, 0, 2'b11);
      issue_start(6'd8, 8);
      repeat (300) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(800);
      s = done_cnt;
      repeat (20) @(negedge clk);
      chk("t4_no_extra_done", done_cnt, s);
      read_char("t4_mine22", xy(2, 2), 8'h2A);
      read_char("t4_n11", xy(1, 1), 8'h31);
      read_char("t4_n33", xy(3, 3), 8'h31);
      read_char("t4_nowrap00", xy(0, 0), 8'h20);
      read_char("t4_n60", xy(6, 0), 8'h31);
      read_char("t4_n71", xy(7, 1), 8'h31);
      read_char("t4_far77", xy(7, 7), 8'h20);

      // Reset during cell 10: cells 0..9 rewritten, no done.
      fill(2'b00);
      @(negedge clk);
      board_dim = 6'd8; start = 1'b1; s = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < s + 115) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_rst_busy", {31'd0, busy}, 0);
      s = done_cnt;
      repeat (30) @(negedge clk);
      chk("t4_rst_no_done", done_cnt, s);
      read_char("t4_rst_new11", xy(1, 1), 8'h20);
      read_char("t4_rst_new01", xy(0, 1), 8'h20);
      read_char("t4_rst_old21", xy(2, 1), 8'h31);
      read_char("t4_rst_old22", xy(2, 2), 8'h2A);

      // board_dim above the maximum clamps to 32.
      fill(2'b10); put(31, 31, 2'b11);
      issue_start(6'd40, 32);
      wait_done(11400);
      read_char("t5_mine3131", xy(31, 31), 8'h2A);
      read_char("t5_n3030", xy(30, 30), 8'h31);
      read_char("t5_n3031", xy(30, 31), 8'h31);
      read_char("t5_nowrap310", xy(31, 0), 8'h20);
      read_char("t5_nowrap031", xy(0, 31), 8'h20);

      // Read of the address being written returns the old code.
      fill(2'b00); put(0, 0, 2'b11);
      issue_start(6'd1, 1);
      while (cyc < start_cyc + 10) @(negedge clk);
      read_char("t6_rw_old", xy(0, 0), 8'h20);
      read_char("t6_rw_new", xy(0, 0), 8'h2A);
      wait_done(50);

      repeat (3) @(negedge clk);
      chk("sb_reads_drained", rd_q.size(), 0);
      chk("sb_done_drained", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
